// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher types, inverse S-box table and GF(2^8) constant multipliers.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [7:0]  aes_byte_t;
  typedef logic [31:0] aes_col_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_state_e;

  // Element 0 sits in the most significant byte so INV_SBOX[b] is a direct lookup.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic aes_byte_t inv_sbox(input aes_byte_t b);
    return INV_SBOX[b];
  endfunction

  function automatic aes_byte_t gf_xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul9(input aes_byte_t b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ b;
  endfunction

  function automatic aes_byte_t gf_mulb(input aes_byte_t b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(b) ^ b;
  endfunction

  function automatic aes_byte_t gf_muld(input aes_byte_t b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ b;
  endfunction

  function automatic aes_byte_t gf_mule(input aes_byte_t b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ gf_xtime(b);
  endfunction

  function automatic aes_col_t inv_mix_col(input aes_col_t c);
    aes_byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
            gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
            gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
            gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// Combinational inverse round: InvShiftRows+InvSubBytes on state_in (sub_out), then
// AddRoundKey and, unless last_round, InvMixColumns on mix_in (state_out).
module aes_inv_round_comb
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  output logic [AES_BLOCK_W-1:0] sub_out,
  input  logic [AES_BLOCK_W-1:0] mix_in,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   last_round,
  output logic [AES_BLOCK_W-1:0] state_out
);

  logic [AES_BLOCK_W-1:0] ark;

  assign ark = mix_in ^ round_key;

  // Byte 4c+r is row r, column c; InvShiftRows pulls from column (c-r) mod 4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = 4 * ((C - R + 4) % 4) + R;
    assign sub_out[127-8*gi -: 8] = inv_sbox(state_in[127-8*SRC -: 8]);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    aes_col_t mixed;
    assign mixed = inv_mix_col(ark[127-32*gi -: 32]);
    assign state_out[127-32*gi -: 32] = last_round ? ark[127-32*gi -: 32] : mixed;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per cycle, round keys fetched via key_idx/key_word.
// Define AES_DEC_PIPE_REG_EN to register between InvSubBytes and AddRoundKey (two cycles per round).
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic [KIDX_W-1:0]      key_idx,
  input  logic [AES_BLOCK_W-1:0] key_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam logic [KIDX_W-1:0] KIDX_NR  = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] KIDX_ONE = KIDX_W'(1);

  aes_state_e             fsm_reg;
  logic [KIDX_W-1:0]      ctr_reg;
  logic [AES_BLOCK_W-1:0] data_reg;
  logic [AES_BLOCK_W-1:0] sub_out;
  logic [AES_BLOCK_W-1:0] mix_in;
  logic [AES_BLOCK_W-1:0] round_out;
  logic                   last_round;
  logic                   advance;

`ifdef AES_DEC_PIPE_REG_EN
  logic                   phase_reg;
  logic [AES_BLOCK_W-1:0] sub_reg;

  assign mix_in  = sub_reg;
  assign advance = phase_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= 1'b0;
      sub_reg   <= '0;
    end else if (fsm_reg == ROUND || fsm_reg == FINAL) begin
      phase_reg <= ~phase_reg;
      if (!phase_reg) sub_reg <= sub_out;
    end
  end
`else
  assign mix_in  = sub_out;
  assign advance = 1'b1;
`endif

  assign last_round = (fsm_reg == FINAL);
  // The counter reaches 0 on entry to FINAL, so it doubles as the key index in every state.
  assign key_idx    = ctr_reg;
  assign in_ready   = (fsm_reg == IDLE);
  assign busy       = (fsm_reg != IDLE);

  aes_inv_round_comb u_round (
    .state_in   (data_reg),
    .sub_out    (sub_out),
    .mix_in     (mix_in),
    .round_key  (key_word),
    .last_round (last_round),
    .state_out  (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= IDLE;
      ctr_reg   <= KIDX_NR;
      data_reg  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: if (in_valid) begin
          data_reg <= in_data ^ key_word;
          ctr_reg  <= KIDX_NR - KIDX_ONE;
          fsm_reg  <= ROUND;
        end
        ROUND: if (advance) begin
          data_reg <= round_out;
          ctr_reg  <= ctr_reg - KIDX_ONE;
          if (ctr_reg == KIDX_ONE) fsm_reg <= FINAL;
        end
        FINAL: if (advance) begin
          out_data  <= round_out;
          out_valid <= 1'b1;
          fsm_reg   <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          ctr_reg   <= KIDX_NR;
          fsm_reg   <= IDLE;
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: table-driven decrypt vectors plus
// back-pressure, back-to-back and mid-block reset sequences.
module tb_aes_inv_cipher_iter;

  localparam int NR     = 10;
  localparam int KIDX_W = 4;
`ifdef AES_DEC_PIPE_REG_EN
  localparam int LAT = 2 * NR;
  localparam int PH  = 2;
`else
  localparam int LAT = NR;
  localparam int PH  = 1;
`endif

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [127:0]      in_data = '0;
  logic              in_ready, out_valid, busy;
  logic [127:0]      key_word, out_data;
  logic [KIDX_W-1:0] key_idx;

  logic [127:0] rk_tab [16];
  logic [7:0]   sbox_t [256];
  vec_t         vecs [6];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  assign key_word = rk_tab[key_idx];

  aes_inv_cipher_iter #(.NR(NR), .KIDX_W(KIDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .key_word(key_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from the field inverse and affine map, independent of the RTL table.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a [4];
    s = pt ^ rk_tab[0];
    for (int rnd = 1; rnd <= NR; rnd++) begin
      for (int i = 0; i < 16; i++)
        t[127-8*i -: 8] = sbox_t[s[127-8*(4*(((i/4)+(i%4))%4)+(i%4)) -: 8]];
      if (rnd != NR) begin
        s = t;
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
          for (int r = 0; r < 4; r++)
            t[127-8*(4*c+r) -: 8] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^
                                    a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      s = t ^ rk_tab[rnd];
    end
    return s;
  endfunction

  task automatic run_block(input int id, input logic [127:0] ct, input logic [127:0] pt);
    int                lat;
    logic              trace_ok;
    logic [KIDX_W-1:0] exp_k;
    @(negedge clk);
    trace_ok = (key_idx === KIDX_W'(NR)) && (in_ready === 1'b1);
    in_valid = 1'b1;
    in_data  = ct;
    lat = -1;
    for (int s = 0; s < LAT + 8; s++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat = s;
        break;
      end
      exp_k = KIDX_W'(NR - 1 - s / PH);
      if (key_idx !== exp_k || busy !== 1'b1 || in_ready !== 1'b0) trace_ok = 1'b0;
    end
    chk("key_idx trace", 128'(trace_ok), 128'(1));
    chk("latency", 128'(lat), 128'(LAT));
    chk("plaintext", out_data, pt);
    $display("block %0d ct=%h pt=%h out=%h lat=%0d", id, ct, pt, out_data, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("done handshake", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    chk("data retained", out_data, pt);
  endtask

  initial begin
    logic         hold_ok;
    int           got1, got2;
    logic [127:0] pt2, ct2;

    for (int i = 0; i < 16; i++) rk_tab[i] = '0;
    init_sbox();

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h0, 128'h0, 128'h0};
    vecs[3] = '{{128{1'b1}}, 128'h0, {128{1'b1}}};
    vecs[4] = '{128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h0, 128'h0123456789abcdeffedcba9876543210};
    vecs[5] = '{128'h5a5a5a5a5a5a5a5aa5a5a5a5a5a5a5a5, 128'h0, 128'h80000000000000000000000000000001};
    for (int i = 2; i < 6; i++) begin
      expand_key(vecs[i].key);
      vecs[i].ct = enc(vecs[i].pt);
    end

    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    chk("reset ready/valid/busy", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("reset out_data", out_data, 128'h0);
    chk("reset key_idx", 128'(key_idx), 128'(NR));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      expand_key(vecs[i].key);
      run_block(i, vecs[i].ct, vecs[i].pt);
    end

    // Back-pressure: result held for 15 cycles while a second block is offered.
    expand_key(vecs[0].key);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = vecs[0].ct;
    got1 = -1;
    for (int s = 0; s < LAT + 8; s++) begin
      @(negedge clk);
      in_data = vecs[4].ct;
      if (out_valid === 1'b1) begin
        got1 = s;
        break;
      end
    end
    chk("bp latency", 128'(got1), 128'(LAT));
    hold_ok = 1'b1;
    for (int s = 0; s < 15; s++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== vecs[0].pt)
        hold_ok = 1'b0;
    end
    chk("bp hold", 128'(hold_ok), 128'(1));
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp no capture", 128'({busy, key_idx}), 128'({1'b0, KIDX_W'(NR)}));
    $display("backpressure block out=%h", out_data);

    // Back-to-back with out_ready held high.
    expand_key(vecs[1].key);
    pt2 = 128'hdeadbeef0123456789abcdeffeedface;
    ct2 = enc(pt2);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = vecs[1].ct;
    out_ready = 1'b1;
    got1 = -1;
    got2 = -1;
    for (int s = 0; s < 3 * LAT + 8; s++) begin
      @(negedge clk);
      in_data = ct2;
      if (out_valid === 1'b1 && got1 < 0) begin
        got1 = s;
        chk("b2b first", out_data, vecs[1].pt);
        $display("b2b block 0 out=%h", out_data);
      end else if (out_valid === 1'b1) begin
        got2 = s;
        chk("b2b second", out_data, pt2);
        $display("b2b block 1 out=%h", out_data);
        break;
      end
    end
    in_valid = 1'b0;
    chk("b2b gap", 128'(got2 - got1), 128'(LAT + 2));
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a block, then a fresh block.
    expand_key(vecs[0].key);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = vecs[0].ct;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset ready/valid/busy", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("midreset out_data", out_data, 128'h0);
    chk("midreset key_idx", 128'(key_idx), 128'(NR));
    @(negedge clk);
    rst_n = 1'b1;
    run_block(6, vecs[0].ct, vecs[0].pt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
